// File: rtl/ysyx_24080014_core_pkg.sv
// Shared types for the multi-cycle core controller: sequencing states, trap causes
// and the load/store funct3 size encodings.
package ysyx_24080014_core_pkg;

   typedef enum logic [2:0] {
      FETCH_REQ,
      FETCH_WAIT,
      EXEC,
      MEM_REQ,
      MEM_WAIT,
      WB,
      HALT
   } state_t;

   localparam logic [1:0] TRAP_NONE     = 2'd0;
   localparam logic [1:0] TRAP_ILLEGAL  = 2'd1;
   localparam logic [1:0] TRAP_BUS      = 2'd2;
   localparam logic [1:0] TRAP_MISALIGN = 2'd3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// Byte-lane steering for the shared memory bus: store shift/strobes, load extract/extend,
// alignment check. Purely combinational, no backpressure of its own.
module ysyx_24080014_lsu_align
   import ysyx_24080014_core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]   addr,
   input  logic [2:0]        size,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   aligned_addr,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN/8-1:0] wmask,
   output logic [XLEN-1:0]   load_data,
   output logic              misaligned
);

   localparam int SW = XLEN / 8;

   logic [1:0]      off;
   logic [XLEN-1:0] shifted;

   assign off          = addr[1:0];
   assign aligned_addr = {addr[XLEN-1:2], 2'b00};
   assign wdata        = store_data << {off, 3'b000};
   assign shifted      = rdata >> {off, 3'b000};

   always_comb begin
      wmask = '1;
      case (size[1:0])
         2'b00:   wmask = {{(SW-1){1'b0}}, 1'b1} << off;
         2'b01:   wmask = {{(SW-2){1'b0}}, 2'b11} << off;
         default: wmask = '1;
      endcase
   end

   always_comb begin
      misaligned = 1'b0;
      case (size[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = off[0];
         default: misaligned = |off;
      endcase
   end

   always_comb begin
      load_data = shifted;
      case (size)
         F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         F3_W:    load_data = shifted;
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/ysyx_24080014_mc_core_ctrl.sv
// Multi-cycle core sequencer: PC/IR ownership, one valid/ready bus for fetch and load/store.
// CPI 4 (ALU) / 6 (load/store) on a zero-wait bus; stalls on ready/response, traps on timeout.
module ysyx_24080014_mc_core_ctrl
   import ysyx_24080014_core_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
   parameter int              TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic              mem_req_wen,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [XLEN/8-1:0] mem_req_wmask,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata,
   input  logic              mem_rsp_err,
   output logic [XLEN-1:0]   pc,
   output logic [31:0]       inst,
   input  logic              dec_is_load,
   input  logic              dec_is_store,
   input  logic              dec_rd_wen,
   input  logic              dec_illegal,
   input  logic [2:0]        dec_mem_size,
   input  logic [XLEN-1:0]   exe_mem_addr,
   input  logic [XLEN-1:0]   exe_store_data,
   input  logic [XLEN-1:0]   exe_rd_data,
   input  logic [XLEN-1:0]   exe_next_pc,
   output logic              gpr_wen,
   output logic [XLEN-1:0]   gpr_wdata,
   output logic              commit_valid,
   output logic              halted,
   output logic [1:0]        trap_cause
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

   state_t            state, next_state;
   logic [1:0]        next_cause;
   logic [31:0]       tmo_cnt;
   logic [XLEN-1:0]   load_raw;
   logic              inst_en, load_en, pc_en, stalled;

   logic [XLEN-1:0]   lane_addr, lane_wdata, load_data;
   logic [XLEN/8-1:0] lane_wmask;
   logic              misaligned;

   // Loads are extended in WB from the latched word; exe_mem_addr is still valid there
   // because inst and the register file are untouched until the WB edge.
   ysyx_24080014_lsu_align #(.XLEN(XLEN)) u_lsu_align (
      .addr         (exe_mem_addr),
      .size         (dec_mem_size),
      .store_data   (exe_store_data),
      .rdata        (load_raw),
      .aligned_addr (lane_addr),
      .wdata        (lane_wdata),
      .wmask        (lane_wmask),
      .load_data    (load_data),
      .misaligned   (misaligned)
   );

   assign halted = (state == HALT);

   always_comb begin
      next_state    = state;
      next_cause    = trap_cause;
      inst_en       = 1'b0;
      load_en       = 1'b0;
      pc_en         = 1'b0;
      stalled       = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = pc;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '0;
      mem_req_wmask = '0;
      gpr_wen       = 1'b0;
      gpr_wdata     = exe_rd_data;
      commit_valid  = 1'b0;

      case (state)
         FETCH_REQ: begin
            mem_req_valid = !rst;
            mem_req_addr  = pc;
            if (mem_req_ready) next_state = FETCH_WAIT;
            else               stalled    = 1'b1;
         end
         FETCH_WAIT: begin
            if (mem_rsp_valid) begin
               if (mem_rsp_err) begin
                  next_state = HALT;
                  next_cause = TRAP_BUS;
               end else begin
                  inst_en    = 1'b1;
                  next_state = EXEC;
               end
            end else begin
               stalled = 1'b1;
            end
         end
         EXEC: begin
            if (dec_illegal) begin
               next_state = HALT;
               next_cause = TRAP_ILLEGAL;
            end else if ((dec_is_load || dec_is_store) && misaligned) begin
               next_state = HALT;
               next_cause = TRAP_MISALIGN;
            end else if (dec_is_load || dec_is_store) begin
               next_state = MEM_REQ;
            end else begin
               next_state = WB;
            end
         end
         MEM_REQ: begin
            mem_req_valid = !rst;
            mem_req_addr  = lane_addr;
            mem_req_wen   = dec_is_store;
            if (dec_is_store) begin
               mem_req_wdata = lane_wdata;
               mem_req_wmask = lane_wmask;
            end
            if (mem_req_ready) next_state = MEM_WAIT;
            else               stalled    = 1'b1;
         end
         MEM_WAIT: begin
            if (mem_rsp_valid) begin
               if (mem_rsp_err) begin
                  next_state = HALT;
                  next_cause = TRAP_BUS;
               end else begin
                  load_en    = dec_is_load;
                  next_state = WB;
               end
            end else begin
               stalled = 1'b1;
            end
         end
         WB: begin
            gpr_wen      = dec_rd_wen;
            gpr_wdata    = dec_is_load ? load_data : exe_rd_data;
            commit_valid = 1'b1;
            pc_en        = 1'b1;
            next_state   = FETCH_REQ;
         end
         default: next_state = HALT;
      endcase

      // A counter at TMO_LAST means this stalled cycle is the TIMEOUT-th one.
      if (stalled && (TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
         next_state = HALT;
         next_cause = TRAP_BUS;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH_REQ;
         pc         <= RESET_PC;
         inst       <= '0;
         load_raw   <= '0;
         trap_cause <= TRAP_NONE;
         tmo_cnt    <= '0;
      end else begin
         state      <= next_state;
         trap_cause <= next_cause;
         if (inst_en) inst     <= mem_rsp_rdata[31:0];
         if (load_en) load_raw <= mem_rsp_rdata;
         if (pc_en)   pc       <= exe_next_pc;
         if (next_state != state) tmo_cnt <= '0;
         else if (stalled)        tmo_cnt <= tmo_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_ysyx_24080014_mc_core_ctrl.sv
// Directed bench for the multi-cycle core sequencer; the bench plays decoder, execute unit and bus.
module tb_ysyx_24080014_mc_core_ctrl;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_rsp_valid, mem_rsp_err;
   logic [31:0] mem_rsp_rdata;
   logic [31:0] pc, inst;
   logic        dec_is_load, dec_is_store, dec_rd_wen, dec_illegal;
   logic [2:0]  dec_mem_size;
   logic [31:0] exe_mem_addr, exe_store_data, exe_rd_data, exe_next_pc;
   logic        gpr_wen, commit_valid, halted;
   logic [31:0] gpr_wdata;
   logic [1:0]  trap_cause;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ysyx_24080014_mc_core_ctrl #(.XLEN(32), .RESET_PC(RST_PC), .TIMEOUT(255)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_rdata  (mem_rsp_rdata),
      .mem_rsp_err    (mem_rsp_err),
      .pc             (pc),
      .inst           (inst),
      .dec_is_load    (dec_is_load),
      .dec_is_store   (dec_is_store),
      .dec_rd_wen     (dec_rd_wen),
      .dec_illegal    (dec_illegal),
      .dec_mem_size   (dec_mem_size),
      .exe_mem_addr   (exe_mem_addr),
      .exe_store_data (exe_store_data),
      .exe_rd_data    (exe_rd_data),
      .exe_next_pc    (exe_next_pc),
      .gpr_wen        (gpr_wen),
      .gpr_wdata      (gpr_wdata),
      .commit_valid   (commit_valid),
      .halted         (halted),
      .trap_cause     (trap_cause)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_dec(input logic ld, input logic st, input logic rdw, input logic ill,
                          input logic [2:0] sz, input logic [31:0] maddr, input logic [31:0] sdata,
                          input logic [31:0] rdd, input logic [31:0] npc);
      dec_is_load    = ld;
      dec_is_store   = st;
      dec_rd_wen     = rdw;
      dec_illegal    = ill;
      dec_mem_size   = sz;
      exe_mem_addr   = maddr;
      exe_store_data = sdata;
      exe_rd_data    = rdd;
      exe_next_pc    = npc;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      mem_rsp_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_pc",      pc, RST_PC);
      check("rst_inst",    inst, 32'h0);
      check("rst_halted",  32'(halted), 32'd0);
      check("rst_cause",   32'(trap_cause), 32'd0);
      check("rst_valid",   32'(mem_req_valid), 32'd0);
      check("rst_gpr_wen", 32'(gpr_wen), 32'd0);
      check("rst_commit",  32'(commit_valid), 32'd0);
      rst = 1'b0;
   endtask

   // Starts in FETCH_REQ, zero-wait handshake and response, returns in EXEC.
   task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] word);
      mem_req_ready = 1'b1;
      #1;
      check("fetch_valid", 32'(mem_req_valid), 32'd1);
      check("fetch_addr",  mem_req_addr, exp_pc);
      check("fetch_wen",   32'(mem_req_wen), 32'd0);
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_err   = 1'b0;
      mem_rsp_rdata = word;
      #1;
      check("fetch_wait_valid", 32'(mem_req_valid), 32'd0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      #1;
      check("fetch_inst", inst, word);
   endtask

   // From EXEC of a non-memory op: WB cycle then back to FETCH_REQ.
   task automatic alu_wb(input logic [31:0] exp_wdata, input logic [31:0] exp_next);
      @(negedge clk);
      #1;
      check("alu_gpr_wen", 32'(gpr_wen), 32'd1);
      check("alu_wdata",   gpr_wdata, exp_wdata);
      check("alu_commit",  32'(commit_valid), 32'd1);
      @(negedge clk);
      #1;
      check("alu_next_pc", pc, exp_next);
   endtask

   // From EXEC of a load/store: MEM_REQ, MEM_WAIT, WB, back to FETCH_REQ.
   task automatic mem_op(input string tag, input logic [31:0] exp_addr, input logic exp_wen,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_wmask,
                         input logic [31:0] rdata, input logic exp_gpr_wen,
                         input logic [31:0] exp_gpr_wdata);
      @(negedge clk);
      mem_req_ready = 1'b1;
      #1;
      check({tag, "_valid"}, 32'(mem_req_valid), 32'd1);
      check({tag, "_addr"},  mem_req_addr, exp_addr);
      check({tag, "_wen"},   32'(mem_req_wen), 32'(exp_wen));
      if (exp_wen) begin
         check({tag, "_wdata"}, mem_req_wdata, exp_wdata);
         check({tag, "_wmask"}, 32'(mem_req_wmask), 32'(exp_wmask));
      end
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      #1;
      check({tag, "_wait_valid"}, 32'(mem_req_valid), 32'd0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      #1;
      check({tag, "_commit"},  32'(commit_valid), 32'd1);
      check({tag, "_gpr_wen"}, 32'(gpr_wen), 32'(exp_gpr_wen));
      if (exp_gpr_wen) check({tag, "_gpr_wdata"}, gpr_wdata, exp_gpr_wdata);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      set_dec(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      do_reset();

      // addi x1,x0,5: write on the 4th cycle, next fetch at +4
      set_dec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'd5, RST_PC + 32'd4);
      fetch(RST_PC, 32'h0050_0093);
      check("exec_pc",      pc, RST_PC);
      check("exec_gpr_wen", 32'(gpr_wen), 32'd0);
      check("exec_valid",   32'(mem_req_valid), 32'd0);
      alu_wb(32'd5, RST_PC + 32'd4);

      set_dec(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h8000_0103, 32'h0, 32'hDEAD_BEEF, RST_PC + 32'd8);
      fetch(RST_PC + 32'd4, 32'h0030_0083);
      mem_op("lb", 32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h80FF_1234, 1'b1, 32'hFFFF_FF80);

      set_dec(1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 32'h8000_0103, 32'h0, 32'hDEAD_BEEF, RST_PC + 32'd12);
      fetch(RST_PC + 32'd8, 32'h0030_4083);
      mem_op("lbu", 32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h80FF_1234, 1'b1, 32'h0000_0080);

      set_dec(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 32'h8000_0102, 32'h0, 32'hDEAD_BEEF, RST_PC + 32'd16);
      fetch(RST_PC + 32'd12, 32'h0020_1083);
      mem_op("lh", 32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h80FF_1234, 1'b1, 32'hFFFF_80FF);

      set_dec(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h8000_0102, 32'h0000_ABCD, 32'h1111, RST_PC + 32'd20);
      fetch(RST_PC + 32'd16, 32'h0010_1123);
      mem_op("sh", 32'h8000_0100, 1'b1, 32'hABCD_0000, 4'b1100, 32'h0, 1'b0, 32'h0);

      // ready held low three cycles during fetch
      set_dec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'd7, RST_PC + 32'd24);
      mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_valid", 32'(mem_req_valid), 32'd1);
         check("stall_addr",  mem_req_addr, RST_PC + 32'd20);
         @(negedge clk);
      end
      fetch(RST_PC + 32'd20, 32'h0070_0093);
      alu_wb(32'd7, RST_PC + 32'd24);

      // LW to a half-aligned address traps without touching the bus
      set_dec(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, RST_PC + 32'd28);
      fetch(RST_PC + 32'd24, 32'h0020_2083);
      check("mis_exec_valid", 32'(mem_req_valid), 32'd0);
      @(negedge clk);
      mem_req_ready = 1'b1;
      #1;
      check("mis_halted", 32'(halted), 32'd1);
      check("mis_cause",  32'(trap_cause), 32'd3);
      check("mis_valid",  32'(mem_req_valid), 32'd0);
      check("mis_pc",     pc, RST_PC + 32'd24);
      repeat (3) @(negedge clk);
      #1;
      check("mis_hold_valid",  32'(mem_req_valid), 32'd0);
      check("mis_hold_commit", 32'(commit_valid), 32'd0);
      check("mis_hold_halted", 32'(halted), 32'd1);

      // illegal / ebreak
      do_reset();
      set_dec(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, RST_PC + 32'd4);
      fetch(RST_PC, 32'h0010_0073);
      @(negedge clk);
      #1;
      check("ill_halted",  32'(halted), 32'd1);
      check("ill_cause",   32'(trap_cause), 32'd1);
      check("ill_gpr_wen", 32'(gpr_wen), 32'd0);
      check("ill_pc",      pc, RST_PC);

      // fetch bus error
      do_reset();
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_err   = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      #1;
      check("ferr_halted", 32'(halted), 32'd1);
      check("ferr_cause",  32'(trap_cause), 32'd2);

      // missing response in MEM_WAIT: trap on the 255th stalled cycle
      do_reset();
      set_dec(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h8000_0200, 32'h0, 32'h0, RST_PC + 32'd4);
      fetch(RST_PC, 32'h2000_2083);
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      repeat (254) @(negedge clk);
      #1;
      check("tmo_not_yet", 32'(halted), 32'd0);
      @(negedge clk);
      #1;
      check("tmo_halted", 32'(halted), 32'd1);
      check("tmo_cause",  32'(trap_cause), 32'd2);
      check("tmo_valid",  32'(mem_req_valid), 32'd0);
      mem_req_ready = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("tmo_no_req", 32'(mem_req_valid), 32'd0);
      check("tmo_pc",     pc, RST_PC);

      // reset while a load is outstanding; the late response must be dropped
      do_reset();
      set_dec(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h8000_0200, 32'h0, 32'h0, RST_PC + 32'd4);
      fetch(RST_PC, 32'h2000_2083);
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst           = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h1234_5678;
      #1;
      check("stale_valid",   32'(mem_req_valid), 32'd1);
      check("stale_addr",    mem_req_addr, RST_PC);
      check("stale_gpr_wen", 32'(gpr_wen), 32'd0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      #1;
      check("stale_gpr_wen2", 32'(gpr_wen), 32'd0);
      check("stale_commit",   32'(commit_valid), 32'd0);
      check("stale_refetch",  32'(mem_req_valid), 32'd1);
      set_dec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'd5, RST_PC + 32'd4);
      fetch(RST_PC, 32'h0050_0093);
      alu_wb(32'd5, RST_PC + 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ysyx_24080014_mc_core_ctrl.md
Name: ysyx_24080014_mc_core_ctrl

Overview:
Multi-cycle successor to the single-cycle CPU top: owns PC, instruction register and a sequencing FSM, and replaces ideal combinational memories with one shared valid/ready memory bus for fetch and load/store. Decoder, immediate generator, ALU and branch unit stay combinational outside this block, fed from the IR and PC and returning results. Adds load sign/zero extension, bus timeout, and a halt/trap state the single-cycle design lacks.

Parameters:
XLEN, 32, datapath and address width (32 only; 64 reserved).
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 255, max cycles waiting for ready/response before a bus-error trap; 0 disables.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
mem_req_valid  out  1  request valid
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  XLEN  byte address (fetch: PC; load/store: exe_mem_addr)
mem_req_wen  out  1  1 = store
mem_req_wdata  out  XLEN  store data, shifted to byte lane
mem_req_wmask  out  XLEN/8  byte write strobes
mem_rsp_valid  in  1  response valid (one per accepted request)
mem_rsp_rdata  in  XLEN  read data, word-aligned lanes
mem_rsp_err  in  1  bus error, qualified by mem_rsp_valid
pc  out  XLEN  current PC
inst  out  32  instruction register
dec_is_load  in  1  IR is a load
dec_is_store  in  1  IR is a store
dec_rd_wen  in  1  IR writes rd
dec_illegal  in  1  IR is illegal or ebreak
dec_mem_size  in  3  funct3 of load/store (LB/LH/LW/LBU/LHU, SB/SH/SW)
exe_mem_addr  in  XLEN  rs1+imm
exe_store_data  in  XLEN  rs2 value
exe_rd_data  in  XLEN  ALU/PC+4/imm result for non-loads
exe_next_pc  in  XLEN  next PC from branch/jump unit
gpr_wen  out  1  register-file write strobe, one cycle
gpr_wdata  out  XLEN  write data
commit_valid  out  1  one-cycle pulse per retired instruction
halted  out  1  sticky after trap
trap_cause  out  2  0 none, 1 illegal/ebreak, 2 bus error, 3 misaligned

Behaviour:
- Reset (rst=1 at edge): state=FETCH_REQ, pc=RESET_PC, inst=0, all strobes 0, halted=0, trap_cause=0, timeout counter 0. Reset wins over every other event, including mid-transaction; responses for requests issued before reset are dropped.
- FETCH_REQ: mem_req_valid=1, addr=pc, wen=0, wmask=0. Handshake on valid&ready -> FETCH_WAIT. valid held and addr/wen/wdata/wmask stable until ready.
- FETCH_WAIT: on rsp_valid: err -> HALT(cause 2); else inst<=rdata -> EXEC. Response in same cycle as request acceptance is not legal (>=1 cycle later).
- EXEC (1 cycle, decode combinational on inst): illegal -> HALT(cause 1). Load/store with addr not aligned to size -> HALT(cause 3). Load/store -> MEM_REQ. Else -> WB.
- MEM_REQ: addr=exe_mem_addr aligned down to word; store: wen=1, wdata=store_data shifted by 8*addr[1:0], wmask SB=4'b0001<<off, SH=4'b0011<<off, SW=4'b1111. Handshake -> MEM_WAIT.
- MEM_WAIT: on rsp_valid: err -> HALT(cause 2); load data latched -> WB; store -> WB.
- WB (1 cycle): gpr_wen=dec_rd_wen; gpr_wdata = load ? extended data : exe_rd_data. Load extract: byte/half at offset addr[1:0], LB/LH sign-extend, LBU/LHU zero-extend. pc<=exe_next_pc, commit_valid=1 -> FETCH_REQ. Minimum CPI: 4 (ALU), 6 (load/store) with zero-wait bus.
- Timeout: counter resets on entering any REQ/WAIT state, increments each stalled cycle; reaching TIMEOUT -> HALT(cause 2).
- HALT: absorbing until rst; mem_req_valid=0, gpr_wen=0, commit_valid=0, halted=1, pc frozen at faulting instruction.
- Operands held stable: inst and pc unchanged from EXEC through WB so external combinational results stay valid.

Decomposition:
- Package ysyx_24080014_core_pkg: FSM state enum (FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT), trap_cause constants, funct3 size constants.
- One sub-module natural: ysyx_24080014_lsu_align (combinational store lane shift/wmask generation, load extract/extend, misalignment detect).

Test Plan:
- Reset then zero-wait bus, addi x1,x0,5 at 0x8000_0000 -> fetch addr 0x8000_0000, gpr_wen with wdata 5 on cycle 4, next fetch 0x8000_0004.
- LB from addr 0x8000_0103, rdata 0x80FF_1234 -> wdata 0xFFFF_FF80; LBU -> 0x0000_0080; LH from 0x...02 -> 0xFFFF_80FF.
- SH data 0x0000_ABCD to 0x8000_0102 -> wdata 0xABCD_0000, wmask 4'b1100, addr 0x8000_0100.
- mem_req_ready low 3 cycles during fetch -> valid/addr stable all 3 cycles, exactly one request accepted.
- No response for 255 cycles in MEM_WAIT -> halted=1, trap_cause=2, no further requests; LW to 0x...02 -> trap_cause=3, no bus request.
- rst asserted in MEM_WAIT, stale rsp_valid next cycle -> ignored, fetch from 0x8000_0000, no gpr_wen.
